mem_port_arb: RTL

Shares the single memory-controller port 0 between two camera write requesters (cam0, cam1) and one display read requester (disp).
- Sits between the per-camera line FIFOs / display prefetch logic and the RAM interface's wr/rd port 0.
- Grants fixed-length bursts, tracks outstanding reads, and routes returned read data back to the display.
- Runs on the pixel clock domain.

---
 rtl/mem_port_arb.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares memory port 0 between two camera writers and one display reader.
// Optional macro STARVE_GUARD_EN promotes a long-waiting camera above the display.
module mem_port_arb #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 8,
`ifdef STARVE_GUARD_EN
    parameter int STARVE_LIM = 64,
`endif
    parameter int MAX_OUTST  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam0_req,
    input  logic [ADDR_W-1:0] cam0_addr,
    input  logic [DATA_W-1:0] cam0_data,
    output logic              cam0_gnt,
    input  logic              cam1_req,
    input  logic [ADDR_W-1:0] cam1_addr,
    input  logic [DATA_W-1:0] cam1_data,
    output logic              cam1_gnt,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rd_data,
    output logic              disp_rd_valid,
    input  logic              mem_wr_rdy,
    input  logic              mem_rd_rdy,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_data_valid,
    output logic [7:0]        outst_cnt,
    output logic              err
);

    typedef enum logic [1:0] {IDLE = 2'd0, WR0 = 2'd1, WR1 = 2'd2, RD = 2'd3} state_t;

    localparam logic [7:0] BURST_C = 8'(BURST_LEN);
    localparam logic [7:0] OUTST_C = 8'(MAX_OUTST);

    state_t            state_r, state_nxt_s;
    logic [7:0]        burst_r, burst_nxt_s, burst_inc_s;
    logic              rr_r, rr_nxt_s;
    logic [7:0]        outst_r;
    logic              err_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              cam0_gnt_s, cam1_gnt_s, disp_gnt_s, rd_room_s;
    logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    assign rd_room_s   = (outst_r < OUTST_C);
    assign burst_inc_s = burst_r + 8'd1;

`ifdef STARVE_GUARD_EN
    localparam int            SW    = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM_C = SW'(STARVE_LIM);

    logic [SW-1:0] wait0_r, wait1_r;
    logic          starve0_s, starve1_s;

    assign starve0_s = cam0_req && (wait0_r >= LIM_C);
    assign starve1_s = cam1_req && (wait1_r >= LIM_C);

    // Per-camera wait counters, saturating at the promotion limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait0_r <= SW'(0);
            wait1_r <= SW'(0);
        end else begin
            if (cam0_gnt_s) begin
                wait0_r <= SW'(0);
            end else if (cam0_req && (state_r != WR0) && (wait0_r < LIM_C)) begin
                wait0_r <= wait0_r + SW'(1);
            end else begin
                wait0_r <= wait0_r;
            end
            if (cam1_gnt_s) begin
                wait1_r <= SW'(0);
            end else if (cam1_req && (state_r != WR1) && (wait1_r < LIM_C)) begin
                wait1_r <= wait1_r + SW'(1);
            end else begin
                wait1_r <= wait1_r;
            end
        end
    end
`endif

    // Arbitration, burst accounting and port-0 muxing for the current owner.
    always_comb begin
        state_nxt_s = state_r;
        burst_nxt_s = burst_r;
        rr_nxt_s    = rr_r;
        cam0_gnt_s  = 1'b0;
        cam1_gnt_s  = 1'b0;
        disp_gnt_s  = 1'b0;
        wr_addr_s   = {ADDR_W{1'b0}};
        wr_data_s   = {DATA_W{1'b0}};
        rd_addr_s   = {ADDR_W{1'b0}};
        case (state_r)
            IDLE: begin
                burst_nxt_s = 8'd0;
`ifdef STARVE_GUARD_EN
                if (starve0_s && starve1_s) begin
                    state_nxt_s = rr_r ? WR1 : WR0;
                    rr_nxt_s    = ~rr_r;
                end else if (starve0_s) begin
                    state_nxt_s = WR0;
                end else if (starve1_s) begin
                    state_nxt_s = WR1;
                end else
`endif
                if (disp_req && rd_room_s) begin
                    state_nxt_s = RD;
                end else if (cam0_req && cam1_req) begin
                    state_nxt_s = rr_r ? WR1 : WR0;
                    rr_nxt_s    = ~rr_r;
                end else if (cam0_req) begin
                    state_nxt_s = WR0;
                end else if (cam1_req) begin
                    state_nxt_s = WR1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR0: begin
                cam0_gnt_s = cam0_req && mem_wr_rdy;
                wr_addr_s  = cam0_addr;
                wr_data_s  = cam0_data;
                if (!cam0_req || (cam0_gnt_s && (burst_inc_s >= BURST_C))) begin
                    state_nxt_s = IDLE;
                    burst_nxt_s = 8'd0;
                end else if (cam0_gnt_s) begin
                    burst_nxt_s = burst_inc_s;
                end else begin
                    burst_nxt_s = burst_r;
                end
            end
            WR1: begin
                cam1_gnt_s = cam1_req && mem_wr_rdy;
                wr_addr_s  = cam1_addr;
                wr_data_s  = cam1_data;
                if (!cam1_req || (cam1_gnt_s && (burst_inc_s >= BURST_C))) begin
                    state_nxt_s = IDLE;
                    burst_nxt_s = 8'd0;
                end else if (cam1_gnt_s) begin
                    burst_nxt_s = burst_inc_s;
                end else begin
                    burst_nxt_s = burst_r;
                end
            end
            RD: begin
                disp_gnt_s = disp_req && mem_rd_rdy && rd_room_s;
                rd_addr_s  = disp_addr;
                // Leave as soon as this grant fills the outstanding window.
                if (!disp_req || !rd_room_s ||
                    (disp_gnt_s && ((burst_inc_s >= BURST_C) || ((outst_r + 8'd1) >= OUTST_C)))) begin
                    state_nxt_s = IDLE;
                    burst_nxt_s = 8'd0;
                end else if (disp_gnt_s) begin
                    burst_nxt_s = burst_inc_s;
                end else begin
                    burst_nxt_s = burst_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                burst_nxt_s = 8'd0;
            end
        endcase
    end

    // State, burst counter and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            burst_r <= 8'd0;
            rr_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            burst_r <= burst_nxt_s;
            rr_r    <= rr_nxt_s;
        end
    end

    // Outstanding-read count and sticky error for unmatched returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outst_r <= 8'd0;
            err_r   <= 1'b0;
        end else begin
            case ({disp_gnt_s, mem_rd_data_valid})
                2'b10:   outst_r <= outst_r + 8'd1;
                2'b01:   outst_r <= (outst_r == 8'd0) ? 8'd0 : (outst_r - 8'd1);
                default: outst_r <= outst_r;
            endcase
            err_r <= err_r | (mem_rd_data_valid && (outst_r == 8'd0));
        end
    end

    // Read return path, registered once toward the display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_r  <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            rd_data_r  <= mem_rd_data;
            rd_valid_r <= mem_rd_data_valid;
        end
    end

    assign cam0_gnt      = cam0_gnt_s;
    assign cam1_gnt      = cam1_gnt_s;
    assign disp_gnt      = disp_gnt_s;
    assign mem_wr_en     = cam0_gnt_s | cam1_gnt_s;
    assign mem_rd_en     = disp_gnt_s;
    assign mem_wr_addr   = wr_addr_s;
    assign mem_wr_data   = wr_data_s;
    assign mem_rd_addr   = rd_addr_s;
    assign disp_rd_data  = rd_data_r;
    assign disp_rd_valid = rd_valid_r;
    assign outst_cnt     = outst_r;
    assign err           = err_r;

endmodule
